// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus bus sequencer feeding the UART transceiver transmit port with write strobes.
// Latency: a push shows up on level/empty one clk later; the strobe starts 2 clk after empty clears, if tx_idle_s is set; the pop comes 2-3 clk after tx_idle falls.
// Backpressure: full at 2**DEPTH_LOG2 bytes; a push while full is dropped unless a pop lands on the same cycle.
module uart_tx_feeder #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter logic [15:0] STROBE_TIMEOUT = 16'd4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  cs_n,
    output logic                  rd_n,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    input  logic                  tx_idle,
    input  logic                  tx_ok,
    output logic                  busy,
    output logic                  sent_pulse,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    localparam int unsigned         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_IDLE = 2'd1;
    localparam logic [1:0] ST_STROBE    = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]            state;
    logic                  tx_idle_m, tx_idle_s;
    logic                  tx_ok_m, tx_ok_s, tx_ok_d;
    logic                  ok_rise;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr, rptr, wptr_nx, rptr_nx;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  full_q, empty_q;
    logic                  push, pop;

    logic [15:0]           tmo_cnt;
    logic                  timeout_hit;
    logic [7:0]            dout_q;
    logic                  sent_q;
    logic                  tmo_err_q;

    // Bring the baud-domain status flags into clk; the FSM only looks at the _s copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_idle_m <= 1'b0;
            tx_idle_s <= 1'b0;
            tx_ok_m   <= 1'b0;
            tx_ok_s   <= 1'b0;
            tx_ok_d   <= 1'b0;
        end else begin
            tx_idle_m <= tx_idle;
            tx_idle_s <= tx_idle_m;
            tx_ok_m   <= tx_ok;
            tx_ok_s   <= tx_ok_m;
            tx_ok_d   <= tx_ok_s;
        end
    end

    assign ok_rise = tx_ok_s & ~tx_ok_d;

    // Pop only when the transmitter has visibly taken the strobed byte; a push
    // into a full FIFO is legal on that same cycle because the head slot frees up.
    assign pop         = (state == ST_STROBE) && !tx_idle_s;
    assign push        = wr_en && (!full_q || pop);
    assign timeout_hit = (state == ST_STROBE) && tx_idle_s &&
                         (tmo_cnt == STROBE_TIMEOUT - 16'd1);
    assign wptr_nx     = push ? (wptr + PTR_ONE) : wptr;
    assign rptr_nx     = pop  ? (rptr + PTR_ONE) : rptr;

    // Byte storage; stale contents are harmless because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Pointers and registered occupancy flags, derived from the next-state pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr    <= wptr_nx;
            rptr    <= rptr_nx;
            level_q <= wptr_nx - rptr_nx;
            full_q  <= (wptr_nx[DEPTH_LOG2] != rptr_nx[DEPTH_LOG2]) &&
                       (wptr_nx[DEPTH_LOG2-1:0] == rptr_nx[DEPTH_LOG2-1:0]);
            empty_q <= (wptr_nx == rptr_nx);
        end
    end

    // Strobe sequencer: wait for idle, hold the strobe until idle drops or the timer expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            dout_q  <= 8'h00;
            tmo_cnt <= 16'd0;
            sent_q  <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty_q) begin
                        state <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (tx_idle_s) begin
                        dout_q  <= mem[rptr[DEPTH_LOG2-1:0]];
                        tmo_cnt <= 16'd0;
                        state   <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (!tx_idle_s) begin
                        state <= ST_WAIT_DONE;
                    end else if (timeout_hit) begin
                        // Same head byte is retried; nothing was popped.
                        state <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ok_rise || tx_idle_s) begin
                        sent_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout on the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_err_q <= 1'b0;
        end else if (timeout_hit) begin
            tmo_err_q <= 1'b1;
        end else if (err_clr) begin
            tmo_err_q <= 1'b0;
        end
    end

    // Strobe pins decode straight from the state register so reset releases cs_n at once
    // and data_oe can never be high with cs_n high.
    assign cs_n        = (state != ST_STROBE);
    assign data_oe     = (state == ST_STROBE);
    assign rd_n        = 1'b1;
    assign data_out    = dout_q;
    assign level       = level_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign busy        = (state != ST_IDLE) || !empty_q;
    assign sent_pulse  = sent_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: random and directed bytes against a queue-based byte-order model
// and a behavioural transmitter; a second instance with a short strobe timeout covers retries.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_feeder;

    logic       clk;
    logic       rst_n;

    logic       wr_en, err_clr, tx_idle, tx_ok;
    logic [7:0] wr_data;
    logic       full, empty, cs_n, rd_n, data_oe, busy, sent_pulse, timeout_err;
    logic [4:0] level;
    logic [7:0] data_out;

    logic       wr_en_b, err_clr_b, tx_idle_b, tx_ok_b;
    logic [7:0] wr_data_b;
    logic       full_b, empty_b, cs_n_b, rd_n_b, data_oe_b, busy_b, sent_pulse_b, timeout_err_b;
    logic [4:0] level_b;
    logic [7:0] data_out_b;

    int errors = 0;
    int checks = 0;

    int sent_cnt   = 0;
    int strobes    = 0;
    int accept_cnt = 0;
    int hold_bad   = 0;
    int oe_bad     = 0;
    int dat_bad    = 0;
    int gap_bad    = 0;
    int max_level  = 0;

    int xm_accept_dly = 20;
    int xm_busy_time  = 1000;
    bit xm_force_busy = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_tx_feeder dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .cs_n(cs_n), .rd_n(rd_n),
        .data_out(data_out), .data_oe(data_oe), .tx_idle(tx_idle), .tx_ok(tx_ok),
        .busy(busy), .sent_pulse(sent_pulse), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    uart_tx_feeder #(.DEPTH_LOG2(4), .STROBE_TIMEOUT(16'd16)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .full(full_b), .empty(empty_b), .level(level_b), .cs_n(cs_n_b), .rd_n(rd_n_b),
        .data_out(data_out_b), .data_oe(data_oe_b), .tx_idle(tx_idle_b), .tx_ok(tx_ok_b),
        .busy(busy_b), .sent_pulse(sent_pulse_b), .timeout_err(timeout_err_b), .err_clr(err_clr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: accepts a strobe some cycles after seeing cs_n low,
    // stays busy, then reports done with tx_ok and idle together.
    initial begin : xmtr
        int low_cnt;
        int busy_cnt;
        int ok_cnt;
        bit xm_busy;
        low_cnt = 0; busy_cnt = 0; ok_cnt = 0; xm_busy = 0;
        tx_idle = 1'b1;
        tx_ok   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (xm_force_busy) begin
                tx_idle = 1'b0; tx_ok = 1'b0;
                low_cnt = 0; busy_cnt = 0; ok_cnt = 0; xm_busy = 0;
            end else if (xm_busy) begin
                if (busy_cnt == 0) begin
                    tx_idle = 1'b1; tx_ok = 1'b1; ok_cnt = 3; xm_busy = 0;
                end else begin
                    busy_cnt--;
                end
            end else begin
                tx_idle = 1'b1;
                if (ok_cnt > 0) begin
                    ok_cnt--;
                    if (ok_cnt == 0) tx_ok = 1'b0;
                end
                if (!cs_n && rst_n) begin
                    low_cnt++;
                    if (low_cnt >= xm_accept_dly) begin
                        got_q.push_back(data_out);
                        accept_cnt++;
                        tx_idle  = 1'b0;
                        xm_busy  = 1;
                        busy_cnt = xm_busy_time;
                        low_cnt  = 0;
                    end
                end else begin
                    low_cnt = 0;
                end
            end
        end
    end

    // Bus-protocol monitor for the main instance.
    initial begin : mon
        logic       prev_cs;
        int         hold;
        int         gap;
        bit         seen;
        logic [7:0] sdat;
        prev_cs = 1'b1; hold = 0; gap = 0; seen = 0; sdat = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs = 1'b1; hold = 0; gap = 0; seen = 0;
            end else begin
                if (data_oe !== !cs_n) oe_bad++;
                if (sent_pulse) sent_cnt++;
                if (int'(level) > max_level) max_level = int'(level);
                if (!cs_n) begin
                    if (prev_cs) begin
                        strobes++;
                        if (seen && gap < 2) gap_bad++;
                        seen = 1; sdat = data_out; hold = 0;
                    end else if (data_out !== sdat) begin
                        dat_bad++;
                    end
                    if (!tx_idle) hold++;
                end else begin
                    if (!prev_cs) begin
                        if (hold < 2 || hold > 3) hold_bad++;
                        gap = 0;
                    end
                    gap++;
                end
                prev_cs = cs_n;
            end
        end
    end

    // Drive one push; the model keeps the byte unless the FIFO already holds 16.
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        if ((exp_q.size() - got_q.size()) < 16) exp_q.push_back(b);
    endtask

    task automatic wait_sent(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (sent_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sent_cnt, target);
    endtask

    task automatic compare_stream(input string tag);
        logic [7:0] g;
        logic [7:0] e;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk(tag, g, e);
        end
        chk({tag, "_cnt"}, got_q.size() + exp_q.size(), 0);
    endtask

    task automatic protocol_checks(input string tag);
        chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_oe"},   oe_bad,   0);
        chk({tag, "_dat"},  dat_bad,  0);
        chk({tag, "_gap"},  gap_bad,  0);
    endtask

    initial begin : main
        int s0;
        int n;
        int base;
        int acc0;

        rst_n = 1'b0;
        wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0;
        wr_en_b = 1'b0; wr_data_b = 8'h00; err_clr_b = 1'b0;
        tx_idle_b = 1'b1; tx_ok_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_oe", data_oe, 0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_sent", sent_pulse, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_b_cs_n", cs_n_b, 1);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Two bytes with a slow transmitter
        xm_accept_dly = 20; xm_busy_time = 1000;
        s0 = strobes; base = sent_cnt;
        push_byte(8'h55);
        push_byte(8'hA3);
        @(negedge clk) wr_en = 1'b0;
        wait_sent(base + 2, 6000, "t1_sent");
        repeat (5) @(negedge clk);
        compare_stream("t1_byte");
        chk("t1_strobes", strobes - s0, 2);
        chk("t1_level", level, 0);
        chk("t1_empty", empty, 1);
        chk("t1_busy", busy, 0);
        chk("t1_rd_n", rd_n, 1);
        protocol_checks("t1");

        // Fill with the transmitter held busy; the 17th byte must be dropped
        xm_force_busy = 1;
        repeat (4) @(negedge clk);
        s0 = strobes;
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        @(negedge clk) wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_level", level, 16);
        chk("t2_full", full, 1);
        chk("t2_empty", empty, 0);
        chk("t2_busy", busy, 1);
        chk("t2_strobes", strobes - s0, 0);

        // Push on the exact cycle of the acceptance pop while full
        xm_accept_dly = 4; xm_busy_time = 30;
        acc0 = accept_cnt; base = sent_cnt;
        xm_force_busy = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (accept_cnt == acc0 && n < 200);
        chk("t3_accept", accept_cnt - acc0, 1);
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hEE;
        exp_q.push_back(8'hEE);
        @(negedge clk) wr_en = 1'b0;
        chk("t3_level", level, 16);
        chk("t3_full", full, 1);
        wait_sent(base + 17, 4000, "t3_sent");
        repeat (5) @(negedge clk);
        compare_stream("t3_byte");
        chk("t3_level_end", level, 0);
        protocol_checks("t3");

        // Reset in the middle of a strobe with 3 bytes queued
        xm_accept_dly = 200;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        @(negedge clk) wr_en = 1'b0;
        n = 0;
        while (cs_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_strobe_up", cs_n, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_cs_n", cs_n, 1);
        chk("t5_oe", data_oe, 0);
        chk("t5_level", level, 0);
        chk("t5_empty", empty, 1);
        s0 = strobes;
        exp_q.delete();
        got_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_no_strobe", strobes - s0, 0);
        chk("t5_busy", busy, 0);
        chk("t5_got", got_q.size(), 0);

        // Pointer wrap: 40 random bytes in bursts of 10
        xm_accept_dly = 3; xm_busy_time = 5;
        max_level = 0;
        for (int burst = 0; burst < 4; burst++) begin
            base = sent_cnt;
            for (int i = 0; i < 10; i++) push_byte(8'($urandom));
            @(negedge clk) wr_en = 1'b0;
            wait_sent(base + 10, 2000, "t6_sent");
            repeat (5) @(negedge clk);
            compare_stream("t6_byte");
        end
        chk("t6_max_le16", max_level <= 16, 1);
        chk("t6_level", level, 0);
        protocol_checks("t6");

        // Timeout and retry on the short-timeout instance (transmitter stuck idle)
        @(negedge clk);
        wr_en_b = 1'b1; wr_data_b = 8'h5A;
        @(negedge clk) wr_en_b = 1'b0;
        n = 0;
        while (cs_n_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_strobe", cs_n_b, 0);
        chk("t4_dout", data_out_b, 8'h5A);
        chk("t4_oe", data_oe_b, 1);
        n = 0;
        while (!cs_n_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_len", n, 16);
        chk("t4_terr", timeout_err_b, 1);
        chk("t4_level", level_b, 1);
        n = 0;
        while (cs_n_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_retry", cs_n_b, 0);
        chk("t4_retry_dout", data_out_b, 8'h5A);
        err_clr_b = 1'b1;
        @(negedge clk) err_clr_b = 1'b0;
        chk("t4_clr", timeout_err_b, 0);
        err_clr_b = 1'b1;
        n = 0;
        while (!cs_n_b && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_set_wins", timeout_err_b, 1);
        @(negedge clk);
        chk("t4_clr_after", timeout_err_b, 0);
        err_clr_b = 1'b0;
        n = 0;
        while (cs_n_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        tx_idle_b = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_pop_level", level_b, 0);
        chk("t4_released", cs_n_b, 1);
        tx_idle_b = 1'b1;
        n = 0;
        while (!sent_pulse_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_sent", sent_pulse_b, 1);
        chk("t4_terr_end", timeout_err_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus bus sequencer that sits directly upstream of the UART transceiver and feeds its transmit side.
- Accepts bytes from the motion-control logic on a simple push interface.
- Presents each byte to the transceiver's bus port as a write strobe (cs_n low, rd_n high, data driven).
- Paces strobes with a handshake on the transceiver's tx_idle/tx_ok, which originate in the baud_clk domain.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes (16).
- STROBE_TIMEOUT, 16'd4096: max clk cycles a strobe is held waiting for the transmitter to go busy.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push strobe, one byte per cycle.
- wr_data  input  8  byte to push.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- level  output  DEPTH_LOG2+1  bytes stored.
- cs_n  output  1  to transceiver cs_n.
- rd_n  output  1  to transceiver rd_n; constant 1 outside reset.
- data_out  output  8  byte for transceiver data bus.
- data_oe  output  1  bus drive enable; integration drives data = data_oe ? data_out : z.
- tx_idle  input  1  transceiver idle (asynchronous to clk).
- tx_ok  input  1  transceiver byte-finished flag (asynchronous to clk).
- busy  output  1  FSM not in IDLE or FIFO non-empty.
- sent_pulse  output  1  one-cycle pulse per completed byte.
- timeout_err  output  1  sticky timeout flag.
- err_clr  input  1  clears timeout_err.

Behaviour:
- Reset values (asynchronous, rst_n=0): FIFO empty, level=0, full=0, empty=1, cs_n=1, rd_n=1, data_oe=0, data_out=8'h00, busy=0, sent_pulse=0, timeout_err=0, FSM=IDLE, synchronizers=0. Reset mid-strobe releases cs_n immediately and discards all contents.
- Synchronization: tx_idle and tx_ok each pass through a 2-flop synchronizer (tx_idle_s, tx_ok_s). tx_ok_s is edge-detected to give ok_rise. All FSM decisions use synchronized signals only.
- FIFO push: wr_en && !full writes wr_data at wptr. Push while full is dropped, with no state change.
- FIFO pop: occurs only on FSM acceptance (see STROBE).
- Simultaneous push and pop: both take effect and level is unchanged. This is legal even when full, because the pop frees the slot.
- Pointers: DEPTH_LOG2+1 bits wide, binary wrap-around. full when MSBs differ and the rest are equal; empty when equal.
- level, full and empty are registered and reflect a push/pop on the cycle after it.
- FSM states:
  - IDLE: if !empty, go to WAIT_IDLE.
  - WAIT_IDLE: when tx_idle_s==1, latch head byte into data_out, clear the timeout counter, go to STROBE.
  - STROBE: cs_n=0, data_oe=1, rd_n=1. Counter increments each cycle.
    - If tx_idle_s==0 (transmitter accepted): pop FIFO, cs_n=1, data_oe=0, go to WAIT_DONE.
    - Else if counter == STROBE_TIMEOUT-1: cs_n=1, data_oe=0, timeout_err=1, no pop, go to WAIT_IDLE (retry same byte).
  - WAIT_DONE: on ok_rise or tx_idle_s==1, assert sent_pulse for one cycle and go to IDLE.
- Strobe length: cs_n is held low at least until tx_idle_s falls. This guarantees capture by the 16x baud_clk regardless of the clk/baud_clk ratio.
- Acceptance latency: the pop happens 2-3 clk after the transmitter clears idle (synchronizer delay).
- data_out is stable for the whole strobe. data_oe is never high while cs_n is high.
- Back-to-back bytes: return to IDLE then WAIT_IDLE. At least 2 clk pass with cs_n=1 between strobes.
- timeout_err: set on timeout; cleared by err_clr. If set and clear coincide, set wins.
- err_clr does not affect the FIFO or the FSM.
- busy = (FSM != IDLE) || !empty.

Test Plan:
- Reset mid-STROBE with 3 bytes queued -> cs_n=1, data_oe=0, level=0, empty=1 within the reset assertion; no further strobes after release.
- Push 8'h55, 8'hA3, model transmitter drops tx_idle 20 clk after cs_n falls and raises tx_ok 1000 clk later -> two strobes in order with data_out 8'h55 then 8'hA3; cs_n low from strobe start until tx_idle_s falls; 2 sent_pulse; level returns to 0.
- Push 17 bytes 8'h00..8'h10 with the transmitter held non-idle -> full=1 at level=16, 17th byte dropped, no strobe issued.
- With the FIFO full, push and acceptance-pop on the same cycle -> level stays 16 and the new byte is sent last.
- tx_idle stuck high (transmitter never accepts), STROBE_TIMEOUT=16 -> cs_n released after 16 clk, timeout_err=1, same byte retried, level unchanged; err_clr pulse -> timeout_err=0.
- Pointer wrap: push/send 40 bytes in bursts of 10 -> byte order preserved across the wrap, level never exceeds 16.
